// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: IDLE/REQ/DONE data-memory access controller with an ack timeout and a sticky bus error.
// Optional feature: define DMEM_ALIGN_CHECK_EN to trap misaligned accesses (adds the misalign port).
module data_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              bus_err
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [9:0] TIMEOUT_C = 10'(ACK_TIMEOUT);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [9:0]          cnt_q, cnt_d;
  logic [9:0]          cnt_inc;
  logic                bus_err_q, bus_err_d;
  logic [31:0]         rdata_q, rdata_d;
`ifdef DMEM_ALIGN_CHECK_EN
  logic                misalign_q, misalign_d;
`endif

  assign cnt_inc = cnt_q + 10'd1;

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no branch can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    bus_err_d  = bus_err_q;
    rdata_d    = rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (memread || memwrite) begin
          addr_d  = addr;
          wdata_d = writedata;
          we_d    = memwrite;
          cnt_d   = '0;
`ifdef DMEM_ALIGN_CHECK_EN
          // Misaligned accesses never reach the bus; they retire through DONE immediately.
          if (addr[1:0] != 2'b00) begin
            state_d    = DONE;
            misalign_d = 1'b1;
            if (!memwrite) rdata_d = '0;
          end else begin
            state_d = REQ;
          end
`else
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          if (!we_q) rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            state_d   = DONE;
            bus_err_d = 1'b1;
            if (!we_q) rdata_d = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      bus_err_q  <= 1'b0;
      rdata_q    <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
      rdata_q    <= rdata_d;
`ifdef DMEM_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Stall is combinational so the processor freezes in the same cycle it issues the access.
  assign stall     = ((state_q == IDLE) && (memread || memwrite)) || (state_q == REQ);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = (state_q == REQ) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign readdata  = rdata_q;
  assign bus_err   = bus_err_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign  = misalign_q;
`endif

endmodule
